// File: rtl/fifo_wr_arb_if.sv
// Write-port bundle between the producers, the round-robin arbiter and the FIFO.
// The master side is the arbiter; the slave side is the producers plus the FIFO flags.
interface fifo_wr_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic                      wr_enb;
    logic [DATA_W-1:0]         wr_data;
    logic                      fifo_full;
    logic                      fifo_almost_full;
    logic                      fifo_overrun;
    logic                      ovr_err;

    modport master (
        input  req, req_data, fifo_full, fifo_almost_full, fifo_overrun,
        output gnt, wr_enb, wr_data, ovr_err
    );

    modport slave (
        output req, req_data, fifo_full, fifo_almost_full, fifo_overrun,
        input  gnt, wr_enb, wr_data, ovr_err
    );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter with burst limit in front of the FIFO write port.
// Define FIFO_WR_ARB_STATS_EN to add the wr_count/stall_count/last_gnt statistics outputs.
module fifo_wr_arb #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    fifo_wr_arb_if.master       bus
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [15:0]         wr_count,
    output logic [15:0]         stall_count,
    output logic [NUM_REQ-1:0]  last_gnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [3:0]         burst_cnt_q, burst_cnt_d;
    logic               wr_enb_q;
    logic [DATA_W-1:0]  wr_data_q;
    logic               ovr_err_q;

    logic [IDX_W-1:0]   pick;
    logic               xfer;
    logic               can_wr;
    logic [NUM_REQ-1:0] gnt_c;
    logic [NUM_REQ-1:0] others;
    logic [DATA_W-1:0]  data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = bus.req_data[i*DATA_W +: DATA_W];
    end

    // A registered write the FIFO has not yet absorbed occupies the last free slot.
    assign can_wr = !bus.fifo_full && !(bus.fifo_almost_full && wr_enb_q);

    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   start);
        logic [IDX_W-1:0] res;
        logic             found;
        res   = start;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            logic [IDX_W-1:0] cand;
            cand = IDX_W'((int'(start) + k) % NUM_REQ);
            if (!found && r[cand]) begin
                res   = cand;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        pick        = owner_q;
        xfer        = 1'b0;
        gnt_c       = '0;
        others      = bus.req & ~(NUM_REQ'(1) << owner_q);

        // Grants are suppressed while reset is applied, since gnt is combinational.
        if (!rst && can_wr) begin
            case (state_q)
                IDLE: begin
                    if (|bus.req) begin
                        pick        = rr_pick(bus.req, last_q);
                        xfer        = 1'b1;
                        owner_d     = pick;
                        burst_cnt_d = 4'd1;
                        state_d     = BURST;
                    end
                end
                BURST: begin
                    if (bus.req[owner_q] && burst_cnt_q < 4'(MAX_BURST)) begin
                        xfer        = 1'b1;
                        burst_cnt_d = burst_cnt_q + 4'd1;
                    end else if (bus.req[owner_q] && others == '0) begin
                        xfer        = 1'b1;
                        burst_cnt_d = 4'd1;
                    end else begin
                        last_d = owner_q;
                        if (|bus.req) begin
                            pick        = rr_pick(bus.req, owner_q);
                            xfer        = 1'b1;
                            owner_d     = pick;
                            burst_cnt_d = 4'd1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (xfer) gnt_c[pick] = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            last_q      <= IDX_W'(NUM_REQ - 1);
            burst_cnt_q <= '0;
            wr_enb_q    <= 1'b0;
            wr_data_q   <= '0;
            ovr_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            wr_enb_q    <= xfer;
            if (xfer) wr_data_q <= data_arr[pick];
            if (bus.fifo_overrun) ovr_err_q <= 1'b1;
        end
    end

    assign bus.gnt     = gnt_c;
    assign bus.wr_enb  = wr_enb_q;
    assign bus.wr_data = wr_data_q;
    assign bus.ovr_err = ovr_err_q;

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0]        wr_count_q;
    logic [15:0]        stall_count_q;
    logic [NUM_REQ-1:0] last_gnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count_q    <= '0;
            stall_count_q <= '0;
            last_gnt_q    <= '0;
        end else begin
            if (wr_enb_q && wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
            if (|bus.req && !can_wr && stall_count_q != 16'hFFFF)
                stall_count_q <= stall_count_q + 16'd1;
            last_gnt_q <= gnt_c;
        end
    end

    assign wr_count    = wr_count_q;
    assign stall_count = stall_count_q;
    assign last_gnt    = last_gnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: directed vector table, corner sequences,
// and randomized traffic against a queue-based FIFO and a behavioural arbiter model.
module tb_fifo_wr_arb;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int MAXB  = 4;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_wr_arb_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0]  wr_count;
    logic [15:0]  stall_count;
    logic [N-1:0] last_gnt;
`endif

    fifo_wr_arb #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MAXB)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .wr_count    (wr_count),
        .stall_count (stall_count),
        .last_gnt    (last_gnt)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Environment: producers, FIFO model
    logic [7:0] base [N];
    int         cnt  [N];
    logic [7:0] q [$];
    logic       env_flags = 1'b0;
    logic       fifo_rd   = 1'b0;
    int         pushes    = 0;
    int         ovr_seen  = 0;
    int         stall_exp = 0;

    // Reference model state (owner -1 means nobody owns the port)
    int         m_owner, m_beats, m_last;
    logic       m_we;
    logic [7:0] m_wd;
    logic       m_can;
    int         n_owner, n_beats, n_last;
    logic       n_we;
    logic [7:0] n_wd;
    logic [3:0] exp_gnt;

    typedef struct {
        logic [3:0] req;
        logic       full;
        logic       af;
        logic [3:0] gnt;
        logic       we;
        logic [7:0] wd;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_next(input logic [3:0] r, input int from);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (from + k) % N;
            if (r[j[1:0]]) return j;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_owner = -1;
        m_beats = 0;
        m_last  = N - 1;
        m_we    = 1'b0;
        m_wd    = 8'h00;
    endtask

    task automatic model_eval();
        int         win;
        logic [3:0] r;
        logic [3:0] oth;
        r       = bus.req;
        m_can   = !bus.fifo_full && !(bus.fifo_almost_full && m_we);
        win     = -1;
        n_owner = m_owner;
        n_beats = m_beats;
        n_last  = m_last;
        if (m_can) begin
            if (m_owner < 0) begin
                win = rr_next(r, m_last);
            end else begin
                oth = r & ~(4'b0001 << m_owner);
                if (r[m_owner[1:0]] && (m_beats < MAXB || oth == 4'b0000)) begin
                    win = m_owner;
                end else begin
                    n_last = m_owner;
                    win    = rr_next(r, m_owner);
                end
            end
            if (m_owner >= 0 && win == m_owner) n_beats = (m_beats < MAXB) ? m_beats + 1 : 1;
            else if (win >= 0)                  n_beats = 1;
            n_owner = win;
        end
        exp_gnt = 4'b0000;
        if (win >= 0) exp_gnt[win[1:0]] = 1'b1;
        n_we = (win >= 0);
        n_wd = (win >= 0) ? bus.req_data[win*DW +: DW] : m_wd;
    endtask

    task automatic drive_data();
        for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = base[i] + 8'(cnt[i]);
    endtask

    // One clock: model predicts and checks gnt before the edge, outputs after it.
    task automatic tick();
        logic [3:0] pg, pr;
        logic       pwe;
        logic [7:0] pwd;
        #1;
        pg  = bus.gnt;
        pr  = bus.req;
        pwe = bus.wr_enb;
        pwd = bus.wr_data;
        model_eval();
        check("model_gnt", 32'(bus.gnt), 32'(exp_gnt));
        if (|bus.req && !m_can) stall_exp++;
        @(posedge clk);
        #1;
        m_owner = n_owner; m_beats = n_beats; m_last = n_last; m_we = n_we; m_wd = n_wd;
        check("model_wr_enb", 32'(bus.wr_enb), 32'(m_we));
        if (m_we) check("model_wr_data", 32'(bus.wr_data), 32'(m_wd));
        if (env_flags) begin
            if (fifo_rd && q.size() > 0) void'(q.pop_front());
            bus.fifo_overrun = 1'b0;
            if (pwe) begin
                if (q.size() < DEPTH) begin
                    q.push_back(pwd);
                    pushes++;
                end else begin
                    bus.fifo_overrun = 1'b1;
                    ovr_seen++;
                end
            end
            bus.fifo_full        = (q.size() == DEPTH);
            bus.fifo_almost_full = (q.size() == DEPTH - 1);
        end
        for (int i = 0; i < N; i++) if (pr[i] && pg[i]) cnt[i]++;
        drive_data();
    endtask

    task automatic do_reset();
        rst                  = 1'b1;
        bus.req              = '0;
        bus.fifo_full        = 1'b0;
        bus.fifo_almost_full = 1'b0;
        bus.fifo_overrun     = 1'b0;
        fifo_rd              = 1'b0;
        env_flags            = 1'b0;
        q.delete();
        for (int i = 0; i < N; i++) cnt[i] = 0;
        m_reset();
        stall_exp = 0;
        pushes    = 0;
        ovr_seen  = 0;
        drive_data();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        base[0] = 8'hA0; base[1] = 8'hB0; base[2] = 8'hC0; base[3] = 8'hD0;

        tbl[0]  = '{4'b0011, 1'b0, 1'b0, 4'b0001, 1'b1, 8'hA0};
        tbl[1]  = '{4'b0011, 1'b0, 1'b0, 4'b0001, 1'b1, 8'hA1};
        tbl[2]  = '{4'b0011, 1'b0, 1'b0, 4'b0001, 1'b1, 8'hA2};
        tbl[3]  = '{4'b0011, 1'b0, 1'b0, 4'b0001, 1'b1, 8'hA3};
        tbl[4]  = '{4'b0011, 1'b0, 1'b0, 4'b0010, 1'b1, 8'hB0};
        tbl[5]  = '{4'b0011, 1'b0, 1'b0, 4'b0010, 1'b1, 8'hB1};
        tbl[6]  = '{4'b0011, 1'b0, 1'b0, 4'b0010, 1'b1, 8'hB2};
        tbl[7]  = '{4'b0011, 1'b0, 1'b0, 4'b0010, 1'b1, 8'hB3};
        tbl[8]  = '{4'b0011, 1'b0, 1'b0, 4'b0001, 1'b1, 8'hA4};
        tbl[9]  = '{4'b0011, 1'b1, 1'b0, 4'b0000, 1'b0, 8'hA4};
        tbl[10] = '{4'b0011, 1'b0, 1'b1, 4'b0001, 1'b1, 8'hA5};
        tbl[11] = '{4'b0011, 1'b0, 1'b1, 4'b0000, 1'b0, 8'hA5};
        tbl[12] = '{4'b0011, 1'b0, 1'b0, 4'b0001, 1'b1, 8'hA6};
        tbl[13] = '{4'b0011, 1'b0, 1'b0, 4'b0001, 1'b1, 8'hA7};
        tbl[14] = '{4'b0011, 1'b0, 1'b0, 4'b0010, 1'b1, 8'hB4};
        tbl[15] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 8'hB4};
        tbl[16] = '{4'b1100, 1'b0, 1'b0, 4'b0100, 1'b1, 8'hC0};

        // Reset state
        do_reset();
        check("rst_wr_enb", 32'(bus.wr_enb), 32'd0);
        check("rst_wr_data", 32'(bus.wr_data), 32'd0);
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_ovr_err", 32'(bus.ovr_err), 32'd0);

        // Burst limit, stalls, owner release, idle restart
        for (int i = 0; i < 17; i++) begin
            bus.req              = tbl[i].req;
            bus.fifo_full        = tbl[i].full;
            bus.fifo_almost_full = tbl[i].af;
            drive_data();
            #1;
            check($sformatf("tbl%0d_gnt", i), 32'(bus.gnt), 32'(tbl[i].gnt));
            tick();
            check($sformatf("tbl%0d_wr_enb", i), 32'(bus.wr_enb), 32'(tbl[i].we));
            check($sformatf("tbl%0d_wr_data", i), 32'(bus.wr_data), 32'(tbl[i].wd));
        end

        // Owner drops early: producer 2 takes over with no bubble
        do_reset();
        bus.req = 4'b0101;
        tick();
        tick();
        bus.req = 4'b0100;
        #1;
        check("drop_gnt", 32'(bus.gnt), 32'b0100);
        tick();
        check("drop_wr_data", 32'(bus.wr_data), 32'hC0);

        // Reset mid-burst
        do_reset();
        bus.req = 4'b1111;
        tick();
        tick();
        rst = 1'b1;
        m_reset();
        #1;
        check("midrst_wr_enb", 32'(bus.wr_enb), 32'd0);
        check("midrst_gnt", 32'(bus.gnt), 32'd0);
        check("midrst_ovr_err", 32'(bus.ovr_err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("midrst_gnt_hold", 32'(bus.gnt), 32'd0);
        rst = 1'b0;
        #1;
        check("postrst_gnt", 32'(bus.gnt), 32'b0001);

        // Fill to full, then drain one and resume
        do_reset();
        env_flags = 1'b1;
        base[0]   = 8'h10;
        drive_data();
        bus.req = 4'b0001;
        repeat (20) tick();
        check("fill_count", 32'(q.size()), 32'd8);
        for (int i = 0; i < q.size(); i++) check($sformatf("fill_q%0d", i), 32'(q[i]), 32'(8'h10 + 8'(i)));
        check("fill_gnt", 32'(bus.gnt), 32'd0);
        check("fill_ovr_seen", 32'(ovr_seen), 32'd0);
        check("fill_ovr_err", 32'(bus.ovr_err), 32'd0);
`ifdef FIFO_WR_ARB_STATS_EN
        check("stats_wr_count", 32'(wr_count), 32'd8);
        check("stats_stall_count", 32'(stall_count), 32'(stall_exp));
`endif
        fifo_rd = 1'b1;
        tick();
        fifo_rd = 1'b0;
        pushes  = 0;
        repeat (6) tick();
        check("drain_pushes", 32'(pushes), 32'd1);
        check("drain_last", 32'(q[q.size()-1]), 32'h18);
        check("drain_gnt", 32'(bus.gnt), 32'd0);
        check("drain_ovr_err", 32'(bus.ovr_err), 32'd0);

        // Overrun is sticky until reset
        do_reset();
        bus.fifo_overrun = 1'b1;
        tick();
        bus.fifo_overrun = 1'b0;
        check("ovr_set", 32'(bus.ovr_err), 32'd1);
        repeat (3) tick();
        check("ovr_sticky", 32'(bus.ovr_err), 32'd1);
        rst = 1'b1;
        m_reset();
        #1;
        check("ovr_cleared", 32'(bus.ovr_err), 32'd0);
        repeat (2) @(posedge clk);
        #1;

        // Randomized traffic against the reference model and FIFO model
        do_reset();
        env_flags = 1'b1;
        for (int i = 0; i < N; i++) base[i] = 8'($urandom_range(0, 255));
        drive_data();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) bus.req[i] = ~bus.req[i];
            fifo_rd = (q.size() > 0) && ($urandom_range(0, 2) == 0);
            tick();
        end
        fifo_rd = 1'b0;
        check("rand_ovr_seen", 32'(ovr_seen), 32'd0);
        check("rand_ovr_err", 32'(bus.ovr_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write arbiter that shares the single write port of the 8-bit `fifo` among `NUM_REQ` producers. It sits between the producer blocks and the FIFO's `wr_enb`/`wr_data` inputs. It grants one producer per cycle, holds the grant for bursts of up to `MAX_BURST` beats, and throttles on the FIFO's `fifo_full`/`fifo_almost_full` flags so the FIFO never overruns.

## Interface
- `NUM_REQ`, 4: number of producers, 2..8.
- `DATA_W`, 8: data width; must match the FIFO.
- `MAX_BURST`, 4: maximum consecutive beats granted to one producer while others wait, 1..15.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input NUM_REQ: per-producer request; `req_data` slice must be valid while high.
- `req_data` input NUM_REQ*DATA_W: producer i data at bits [i*DATA_W +: DATA_W].
- `gnt` output NUM_REQ: one-hot, combinational; a beat transfers at a posedge where `req[i] & gnt[i]`.
- `wr_enb` output 1: registered write enable to the FIFO.
- `wr_data` output DATA_W: registered write data to the FIFO.
- `fifo_full` input 1: FIFO full flag.
- `fifo_almost_full` input 1: FIFO holds DEPTH-1 entries.
- `fifo_overrun` input 1: FIFO overrun pulse.
- `ovr_err` output 1: sticky, set when `fifo_overrun` is seen; cleared only by `rst`.

## Operation
- **Reset values:** `wr_enb`=0, `wr_data`=0, `gnt`=0, `ovr_err`=0, state IDLE, `burst_cnt`=0, `last`=NUM_REQ-1 (so producer 0 wins first).
- **Write permission:** `can_wr = !fifo_full && !(fifo_almost_full && wr_enb)`.
  - A write already registered but not yet taken by the FIFO counts as occupying the last slot.
  - When `can_wr`=0, `gnt`=0 regardless of `req`.
- **State IDLE:** no owner.
  - If `can_wr` and any `req`, grant the first requester searching from `last+1` upward with wrap-around.
  - On transfer: owner = winner, `burst_cnt`=1, go to BURST.
- **State BURST:** owner o.
  - Keep granting o while `req[o]` and `burst_cnt < MAX_BURST`. Each transfer increments `burst_cnt`.
  - If `burst_cnt == MAX_BURST` and another producer requests, set `last`=o. The next grant that same cycle goes to the next requester by the round-robin search; it becomes the new owner with `burst_cnt`=1.
  - If `burst_cnt == MAX_BURST` and only o requests, o keeps the grant and `burst_cnt` resets to 1.
  - If `req[o]` drops: set `last`=o and run a round-robin search the same cycle. Go to IDLE if nobody requests.
  - A stall (`can_wr`=0) freezes owner and `burst_cnt`; no grant is issued.
- **Output register:** on each transfer posedge, `wr_enb`<=1 and `wr_data`<=`req_data[owner]`. Otherwise `wr_enb`<=0 and `wr_data` holds its value.
- **Width rules:** `burst_cnt` is 4 bits; `last` is $clog2(NUM_REQ) bits.
- **Mid-operation reset:** `rst` asserted mid-operation clears everything immediately. Any pending `wr_enb` is dropped.

## Timing
- Throughput: 1 beat/cycle while `can_wr`=1.
- Latency: transfer edge to `wr_enb` high is 0 cycles (registered at that edge). The FIFO captures data at the next edge.
- `gnt` is combinational from `req`, state, `fifo_full`, `fifo_almost_full` and `wr_enb`. Producers must not make `req` depend combinationally on `gnt`.
- Simultaneous requests: resolved in the same cycle, with no idle bubble between owners.
- Near full: with almost_full high, exactly one further write is issued; the next cycle is a stall.

## Configuration
- `FIFO_WR_ARB_STATS_EN` defined adds three outputs, all cleared by `rst`:
  - `wr_count` [15:0]: counts `wr_enb` cycles, saturating at 16'hFFFF.
  - `stall_count` [15:0]: counts cycles with `|req && !can_wr`, saturating at 16'hFFFF.
  - `last_gnt` [NUM_REQ-1:0]: registered copy of the most recent `gnt`.
- Undefined: these ports and counters do not exist. Arbitration behaviour is identical either way.

## Test plan
- **Reset:** assert `rst` for 2 cycles mid-burst -> `wr_enb`=0, `gnt`=0, `ovr_err`=0. Afterwards, `req`=4'b1111 yields `gnt`=4'b0001 first.
- **Burst limit:** NUM_REQ=4, MAX_BURST=4, `req`=4'b0011 held, data 8'hA0/8'hB0 incrementing -> FIFO sees A0,A1,A2,A3,B0,B1,B2,B3,A4, with no idle cycles.
- **Fill to full:** FIFO depth 8, single producer writing 8'h10..8'h1F -> exactly 8 writes (10..17) are accepted. `gnt` drops, `fifo_overrun` never pulses, `ovr_err`=0.
- **Drain and resume:** after the fill-to-full case, read one entry -> exactly one further grant (8'h18), then stall again.
- **Owner drops early:** `req`=4'b0101, producer 0 drops after 2 beats -> producer 2 is granted the next cycle; `last`=0.
- **Overrun and stats:** force a `fifo_overrun` pulse -> `ovr_err` sticks at 1 until `rst`. With `FIFO_WR_ARB_STATS_EN` defined, the fill-to-full case gives `wr_count`=8 and `stall_count` = stalled cycles.
